armleocpu_decode: RTL and testbench
===================================

# armleocpu_decode

Decode stage of the 3-stage pipeline, between fetch and execute. Accepts one F2D beat at a time into a single output register and extracts register indices and a sign-extended immediate. Flags illegal encodings and holds serializing instructions. Forwards execute's branch/flush commands combinationally to fetch on the D2F bus, killing any in-flight instruction.

## Interface
Parameters:
- none; all widths come from `armleocpu_defines.vh`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `f2d_valid`  in  1  fetch beat valid.
- `f2d_type`  in  `F2E_TYPE_WIDTH`  `F2E_TYPE_INSTR` or `F2E_TYPE_INTERRUPT_PENDING`.
- `f2d_instr`, `f2d_pc`  in  32 each  instruction word and its address.
- `d2f_ready`  out  1  beat accepted this cycle; also qualifies `d2f_cmd`.
- `d2f_cmd`  out  `ARMLEOCPU_D2F_CMD_WIDTH`  NONE / START_BRANCH / FLUSH.
- `d2f_branchtarget`  out  32  branch target.
- `d2e_valid`  out  1  output register holds a beat.
- `d2e_type`  out  `F2E_TYPE_WIDTH`  registered `f2d_type`.
- `d2e_instr`, `d2e_pc`  out  32 each  registered instruction and PC.
- `d2e_rs1`, `d2e_rs2`, `d2e_rd`  out  5 each  instr[19:15], [24:20], [11:7].
- `d2e_imm`  out  32  sign-extended immediate per format.
- `d2e_illegal`  out  1  encoding not in RV32I+Zicsr+Zifencei.
- `e2d_ready`  in  1  execute consumes the d2e beat this cycle.
- `e2d_cmd`  in  `ARMLEOCPU_D2F_CMD_WIDTH`  one-cycle command from execute.
- `e2d_branchtarget`  in  32  target for START_BRANCH.
- `dbg_pipeline_busy`  out  1  stage holds or waits on work.

## Operation
- `kill = (e2d_cmd != NONE)`.
- Combinational command forwarding:
  - `d2f_cmd = e2d_cmd`.
  - `d2f_branchtarget = e2d_branchtarget`.
- Ready rule: `d2f_ready = kill || (!serializing && (!d2e_valid || e2d_ready))`.
- Kill cycle:
  - The `f2d` beat is dropped.
  - `d2e_valid` clears next cycle.
  - `serializing` clears.
- Capture, when `f2d_valid && d2f_ready && !kill`:
  - Load type, instr, pc and the decoded fields.
  - Set `d2e_valid`.
- Consume without capture (`e2d_ready && d2e_valid`, no new beat): clear `d2e_valid`.
- Serializing beats set `serializing` at capture:
  - opcode SYSTEM (1110011), including ECALL, EBREAK, MRET, WFI and CSR*;
  - MISC-MEM (0001111), covering FENCE and FENCE.I;
  - any `F2E_TYPE_INTERRUPT_PENDING` beat;
  - any illegal encoding.
- While `serializing` is set, `d2f_ready` stays 0 until a kill. Execute must end every serializing instruction with START_BRANCH (e.g. to pc+4) or FLUSH.
- Illegal encodings:
  - `instr[1:0] != 2'b11`;
  - opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM};
  - invalid funct3/funct7 for that opcode.
- Immediate format by opcode: I (OP-IMM, LOAD, JALR, SYSTEM), S, B, U, J. Any other opcode gives 0. B and J immediates have bit0 = 0.
- Interrupt beats: `d2e_illegal` = 0, `d2e_imm` = 0.
- `dbg_pipeline_busy = d2e_valid || serializing`.

## Timing
- Latency: f2d to d2e is 1 cycle; e2d_cmd to d2f_cmd is 0 cycles (combinational path).
- Back-to-back: one beat per cycle when `e2d_ready` = 1 and no serializing instruction is present.
- `d2e_*` stays stable while `d2e_valid && !e2d_ready && !kill`.
- Kill and `e2d_ready` in the same cycle: kill wins. The beat counts as consumed and no new beat is captured.
- Reset state: `d2e_valid` = 0, `serializing` = 0.
- Outputs during reset:
  - `d2f_ready` = 0, `d2f_cmd` = NONE (e2d ignored), `dbg_pipeline_busy` = 0;
  - `d2e_type`/`d2e_instr`/`d2e_pc`/`d2e_imm`/`d2e_rs*`/`d2e_rd` = 0, `d2e_illegal` = 0.
- Reset mid-stall drops both the held beat and `serializing`.

## Structure
- Opcode constants (7-bit), funct3 values for SYSTEM/MISC-MEM and immediate-format encodings go in `armleocpu_defines.vh`.
- Sub-module `armleocpu_decode_imm`: purely combinational, takes instr[31:0] and returns imm[31:0] plus the illegal flag.
- The top level holds the output register, `serializing`, and the ready/kill logic.

## Test plan
- Three ADDI beats (pc 0x1000, 0x1004, 0x1008) with `e2d_ready` = 1: each appears on d2e one cycle later. `d2e_imm` = 0xFFFFFFFF for `addi x1,x0,-1`.
- Back-pressure: `e2d_ready` = 0 for 3 cycles with `d2e_valid` = 1. `d2f_ready` = 0 and d2e stays stable. When released, the next beat is captured in the same cycle.
- CSRRW captured: `d2f_ready` = 0 while f2d stays valid. Execute issues START_BRANCH to 0x2004: `d2f_cmd` = START_BRANCH and `d2f_branchtarget` = 0x2004 in the same cycle, `d2f_ready` = 1, and `d2e_valid` = 0 next cycle.
- Kill with `f2d_valid` = 1 (instr 0x00000013): beat dropped, `d2e_valid` = 0 next cycle.
- Instr 0x00000000 gives `d2e_illegal` = 1 and serializing. Interrupt-pending beat gives `d2e_type` = INTERRUPT_PENDING with `d2f_ready` held low until FLUSH.
- `rst` asserted while serializing: the next cycle `d2e_valid` = 0, `dbg_pipeline_busy` = 0, and `d2f_ready` = 1 after `rst` deasserts.

Source files
------------

// File: rtl/armleocpu_decode_pkg.sv
`default_nettype none
// armleocpu_decode_pkg: shared widths, opcodes, funct3 values and immediate formats for the decode stage.
// Revision: 1.0
package armleocpu_decode_pkg;

    localparam int F2E_TYPE_WIDTH = 2;
    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR             = 2'd0;
    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING = 2'd1;

    localparam int ARMLEOCPU_D2F_CMD_WIDTH = 2;
    localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] ARMLEOCPU_D2F_CMD_NONE         = 2'd0;
    localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] ARMLEOCPU_D2F_CMD_START_BRANCH = 2'd1;
    localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] ARMLEOCPU_D2F_CMD_FLUSH        = 2'd2;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FUNCT3_SYSTEM_PRIV  = 3'b000;
    localparam logic [2:0] FUNCT3_SYSTEM_RSVD  = 3'b100;
    localparam logic [2:0] FUNCT3_MISC_FENCE   = 3'b000;
    localparam logic [2:0] FUNCT3_MISC_FENCE_I = 3'b001;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Privileged SYSTEM encodings are fixed words (funct3 == 0).
    localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;
    localparam logic [31:0] INSTR_MRET   = 32'h30200073;
    localparam logic [31:0] INSTR_WFI    = 32'h10500073;

    typedef enum logic [2:0] {
        IMM_FMT_NONE = 3'd0,
        IMM_FMT_I    = 3'd1,
        IMM_FMT_S    = 3'd2,
        IMM_FMT_B    = 3'd3,
        IMM_FMT_U    = 3'd4,
        IMM_FMT_J    = 3'd5
    } imm_fmt_t;

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_SYSTEM: return IMM_FMT_I;
            OPCODE_STORE:                                           return IMM_FMT_S;
            OPCODE_BRANCH:                                          return IMM_FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:                               return IMM_FMT_U;
            OPCODE_JAL:                                             return IMM_FMT_J;
            default:                                                return IMM_FMT_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/armleocpu_decode_imm.sv
`default_nettype none
// armleocpu_decode_imm: combinational immediate extraction and RV32I+Zicsr+Zifencei legality check.
// Revision: 1.0
module armleocpu_decode_imm
    import armleocpu_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal_op;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        imm = 32'd0;
        case (imm_fmt_of(opcode))
            IMM_FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_FMT_U: imm = {instr[31:12], 12'd0};
            IMM_FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   imm = 32'd0;
        endcase
    end

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: legal_op = 1'b1;
            OPCODE_JALR:   legal_op = (funct3 == 3'b000);
            OPCODE_BRANCH: legal_op = (funct3 != 3'b010) && (funct3 != 3'b011);
            OPCODE_LOAD:   legal_op = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            OPCODE_STORE:  legal_op = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            OPCODE_OP_IMM: begin
                // Only the shift forms constrain funct7.
                if (funct3 == 3'b001)
                    legal_op = (funct7 == FUNCT7_BASE);
                else if (funct3 == 3'b101)
                    legal_op = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                else
                    legal_op = 1'b1;
            end
            OPCODE_OP: begin
                if (funct7 == FUNCT7_BASE)
                    legal_op = 1'b1;
                else if (funct7 == FUNCT7_ALT)
                    legal_op = (funct3 == 3'b000) || (funct3 == 3'b101);
                else
                    legal_op = 1'b0;
            end
            OPCODE_MISC_MEM: legal_op = (funct3 == FUNCT3_MISC_FENCE) || (funct3 == FUNCT3_MISC_FENCE_I);
            OPCODE_SYSTEM: begin
                if (funct3 == FUNCT3_SYSTEM_PRIV)
                    legal_op = (instr == INSTR_ECALL) || (instr == INSTR_EBREAK) ||
                               (instr == INSTR_MRET)  || (instr == INSTR_WFI);
                else
                    legal_op = (funct3 != FUNCT3_SYSTEM_RSVD);
            end
            default: legal_op = 1'b0;
        endcase
    end

    assign illegal = (instr[1:0] != 2'b11) || !legal_op;

endmodule
`default_nettype wire

// File: rtl/armleocpu_decode.sv
`default_nettype none
// armleocpu_decode: single-register decode stage between fetch and execute with kill/serialize control.
// Revision: 1.0
module armleocpu_decode
    import armleocpu_decode_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               f2d_valid,
    input  logic [F2E_TYPE_WIDTH-1:0]          f2d_type,
    input  logic [31:0]                        f2d_instr,
    input  logic [31:0]                        f2d_pc,

    output logic                               d2f_ready,
    output logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
    output logic [31:0]                        d2f_branchtarget,

    output logic                               d2e_valid,
    output logic [F2E_TYPE_WIDTH-1:0]          d2e_type,
    output logic [31:0]                        d2e_instr,
    output logic [31:0]                        d2e_pc,
    output logic [4:0]                         d2e_rs1,
    output logic [4:0]                         d2e_rs2,
    output logic [4:0]                         d2e_rd,
    output logic [31:0]                        d2e_imm,
    output logic                               d2e_illegal,

    input  logic                               e2d_ready,
    input  logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] e2d_cmd,
    input  logic [31:0]                        e2d_branchtarget,

    output logic                               dbg_pipeline_busy
);

    logic                      held_valid;
    logic                      serializing;
    logic [F2E_TYPE_WIDTH-1:0] held_type;
    logic [31:0]               held_instr;
    logic [31:0]               held_pc;
    logic [4:0]                held_rs1;
    logic [4:0]                held_rs2;
    logic [4:0]                held_rd;
    logic [31:0]               held_imm;
    logic                      held_illegal;

    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic        is_interrupt;
    logic        beat_illegal;
    logic        beat_serializing;
    logic        kill;
    logic        ready;
    logic        capture;

    armleocpu_decode_imm u_imm (
        .instr   (f2d_instr),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign is_interrupt     = (f2d_type == F2E_TYPE_INTERRUPT_PENDING);
    assign beat_illegal     = !is_interrupt && dec_illegal;
    assign beat_serializing = is_interrupt || beat_illegal ||
                              (f2d_instr[6:0] == OPCODE_SYSTEM) ||
                              (f2d_instr[6:0] == OPCODE_MISC_MEM);

    // Execute commands are ignored while in reset so fetch never sees a stray branch.
    assign kill    = !rst && (e2d_cmd != ARMLEOCPU_D2F_CMD_NONE);
    assign ready   = !rst && (kill || (!serializing && (!held_valid || e2d_ready)));
    assign capture = f2d_valid && ready && !kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid   <= 1'b0;
            serializing  <= 1'b0;
            held_type    <= '0;
            held_instr   <= 32'd0;
            held_pc      <= 32'd0;
            held_rs1     <= 5'd0;
            held_rs2     <= 5'd0;
            held_rd      <= 5'd0;
            held_imm     <= 32'd0;
            held_illegal <= 1'b0;
        end else if (kill) begin
            held_valid  <= 1'b0;
            serializing <= 1'b0;
        end else if (capture) begin
            held_valid   <= 1'b1;
            serializing  <= beat_serializing;
            held_type    <= f2d_type;
            held_instr   <= f2d_instr;
            held_pc      <= f2d_pc;
            held_rs1     <= f2d_instr[19:15];
            held_rs2     <= f2d_instr[24:20];
            held_rd      <= f2d_instr[11:7];
            held_imm     <= is_interrupt ? 32'd0 : dec_imm;
            held_illegal <= beat_illegal;
        end else if (e2d_ready && held_valid) begin
            held_valid <= 1'b0;
        end
    end

    assign d2f_ready        = ready;
    assign d2f_cmd          = rst ? ARMLEOCPU_D2F_CMD_NONE : e2d_cmd;
    assign d2f_branchtarget = e2d_branchtarget;

    // Outputs read as zero for the whole reset cycle, not only after the first edge.
    assign d2e_valid         = !rst && held_valid;
    assign d2e_type          = rst ? '0 : held_type;
    assign d2e_instr         = rst ? 32'd0 : held_instr;
    assign d2e_pc            = rst ? 32'd0 : held_pc;
    assign d2e_rs1           = rst ? 5'd0 : held_rs1;
    assign d2e_rs2           = rst ? 5'd0 : held_rs2;
    assign d2e_rd            = rst ? 5'd0 : held_rd;
    assign d2e_imm           = rst ? 32'd0 : held_imm;
    assign d2e_illegal       = !rst && held_illegal;
    assign dbg_pipeline_busy = !rst && (held_valid || serializing);

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_decode.sv
`default_nettype none
// tb_armleocpu_decode: table-driven and directed sequence checks for the decode stage.
// Revision: 1.0
module tb_armleocpu_decode;
    import armleocpu_decode_pkg::*;

    logic        clk;
    logic        rst;
    logic        f2d_valid;
    logic [1:0]  f2d_type;
    logic [31:0] f2d_instr;
    logic [31:0] f2d_pc;
    logic        d2f_ready;
    logic [1:0]  d2f_cmd;
    logic [31:0] d2f_branchtarget;
    logic        d2e_valid;
    logic [1:0]  d2e_type;
    logic [31:0] d2e_instr;
    logic [31:0] d2e_pc;
    logic [4:0]  d2e_rs1;
    logic [4:0]  d2e_rs2;
    logic [4:0]  d2e_rd;
    logic [31:0] d2e_imm;
    logic        d2e_illegal;
    logic        e2d_ready;
    logic [1:0]  e2d_cmd;
    logic [31:0] e2d_branchtarget;
    logic        dbg_pipeline_busy;

    int checks = 0;
    int errors = 0;

    armleocpu_decode dut (
        .clk               (clk),
        .rst               (rst),
        .f2d_valid         (f2d_valid),
        .f2d_type          (f2d_type),
        .f2d_instr         (f2d_instr),
        .f2d_pc            (f2d_pc),
        .d2f_ready         (d2f_ready),
        .d2f_cmd           (d2f_cmd),
        .d2f_branchtarget  (d2f_branchtarget),
        .d2e_valid         (d2e_valid),
        .d2e_type          (d2e_type),
        .d2e_instr         (d2e_instr),
        .d2e_pc            (d2e_pc),
        .d2e_rs1           (d2e_rs1),
        .d2e_rs2           (d2e_rs2),
        .d2e_rd            (d2e_rd),
        .d2e_imm           (d2e_imm),
        .d2e_illegal       (d2e_illegal),
        .e2d_ready         (e2d_ready),
        .e2d_cmd           (e2d_cmd),
        .e2d_branchtarget  (e2d_branchtarget),
        .dbg_pipeline_busy (dbg_pipeline_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        illegal;
        logic        ser;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1'b0, 1'b0}; // addi x1,x0,-1
        vecs[1]  = '{32'h123452B7, 32'h12345000, 1'b0, 1'b0}; // lui x5,0x12345
        vecs[2]  = '{32'h0020A423, 32'h00000008, 1'b0, 1'b0}; // sw x2,8(x1)
        vecs[3]  = '{32'hFE208EE3, 32'hFFFFFFFC, 1'b0, 1'b0}; // beq x1,x2,-4
        vecs[4]  = '{32'h001000EF, 32'h00000800, 1'b0, 1'b0}; // jal x1,2048
        vecs[5]  = '{32'h002081B3, 32'h00000000, 1'b0, 1'b0}; // add x3,x1,x2
        vecs[6]  = '{32'h402091B3, 32'h00000000, 1'b1, 1'b1}; // OP funct7=0100000 funct3=001
        vecs[7]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1}; // all zero
        vecs[8]  = '{32'h30009073, 32'h00000300, 1'b0, 1'b1}; // csrrw x0,mstatus,x1
        vecs[9]  = '{32'h0FF0000F, 32'h00000000, 1'b0, 1'b1}; // fence
        vecs[10] = '{32'h00000073, 32'h00000000, 1'b0, 1'b1}; // ecall
        vecs[11] = '{32'h00003003, 32'h00000000, 1'b1, 1'b1}; // load funct3=011
        vecs[12] = '{32'h4030D093, 32'h00000403, 1'b0, 1'b0}; // srai x1,x1,3
        vecs[13] = '{32'hFFFFF117, 32'hFFFFF000, 1'b0, 1'b0}; // auipc x2,0xFFFFF
        vecs[14] = '{32'h000010E7, 32'h00000000, 1'b1, 1'b1}; // jalr funct3=001

        rst = 1'b1;
        f2d_valid = 1'b0;
        f2d_type = F2E_TYPE_INSTR;
        f2d_instr = 32'd0;
        f2d_pc = 32'd0;
        e2d_ready = 1'b0;
        e2d_cmd = ARMLEOCPU_D2F_CMD_NONE;
        e2d_branchtarget = 32'd0;

        tick();
        tick();
        check("rst_d2e_valid", {31'd0, d2e_valid}, 32'd0);
        check("rst_d2f_ready", {31'd0, d2f_ready}, 32'd0);
        check("rst_busy", {31'd0, dbg_pipeline_busy}, 32'd0);
        check("rst_d2e_instr", d2e_instr, 32'd0);
        e2d_cmd = ARMLEOCPU_D2F_CMD_FLUSH;
        #1;
        check("rst_d2f_cmd_none", {30'd0, d2f_cmd}, 32'd0);
        e2d_cmd = ARMLEOCPU_D2F_CMD_NONE;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, d2f_ready}, 32'd1);

        // Table: one beat each, then consume or flush
        for (int i = 0; i < 15; i++) begin
            logic [31:0] ins;
            ins = vecs[i].instr;
            f2d_valid = 1'b1;
            f2d_type = F2E_TYPE_INSTR;
            f2d_instr = ins;
            f2d_pc = 32'h100 + i * 4;
            e2d_ready = 1'b1;
            #1;
            check($sformatf("v%0d_ready_in", i), {31'd0, d2f_ready}, 32'd1);
            tick();
            f2d_valid = 1'b0;
            check($sformatf("v%0d_valid", i), {31'd0, d2e_valid}, 32'd1);
            check($sformatf("v%0d_instr", i), d2e_instr, ins);
            check($sformatf("v%0d_pc", i), d2e_pc, 32'h100 + i * 4);
            check($sformatf("v%0d_imm", i), d2e_imm, vecs[i].imm);
            check($sformatf("v%0d_illegal", i), {31'd0, d2e_illegal}, {31'd0, vecs[i].illegal});
            check($sformatf("v%0d_rs1", i), {27'd0, d2e_rs1}, {27'd0, ins[19:15]});
            check($sformatf("v%0d_rs2", i), {27'd0, d2e_rs2}, {27'd0, ins[24:20]});
            check($sformatf("v%0d_rd", i), {27'd0, d2e_rd}, {27'd0, ins[11:7]});
            check($sformatf("v%0d_ready_held", i), {31'd0, d2f_ready}, {31'd0, !vecs[i].ser});
            if (vecs[i].ser) begin
                e2d_cmd = ARMLEOCPU_D2F_CMD_FLUSH;
                #1;
                check($sformatf("v%0d_ready_flush", i), {31'd0, d2f_ready}, 32'd1);
            end
            tick();
            e2d_cmd = ARMLEOCPU_D2F_CMD_NONE;
            check($sformatf("v%0d_drained", i), {31'd0, d2e_valid}, 32'd0);
            check($sformatf("v%0d_idle", i), {31'd0, dbg_pipeline_busy}, 32'd0);
        end

        // Three ADDI back-to-back
        e2d_ready = 1'b1;
        f2d_valid = 1'b1;
        f2d_type = F2E_TYPE_INSTR;
        for (int i = 0; i < 3; i++) begin
            f2d_pc = 32'h1000 + i * 4;
            f2d_instr = (i == 0) ? 32'hFFF00093 : 32'h00100093;
            tick();
            check($sformatf("b2b%0d_pc", i), d2e_pc, 32'h1000 + i * 4);
            check($sformatf("b2b%0d_valid", i), {31'd0, d2e_valid}, 32'd1);
            if (i == 0) check("b2b0_imm", d2e_imm, 32'hFFFFFFFF);
        end
        f2d_valid = 1'b0;
        tick();
        check("b2b_drain", {31'd0, d2e_valid}, 32'd0);

        // Back-pressure
        f2d_valid = 1'b1;
        f2d_pc = 32'h3000;
        f2d_instr = 32'h00100093;
        e2d_ready = 1'b0;
        tick();
        f2d_pc = 32'h3004;
        f2d_instr = 32'h00200113;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp%0d_ready", i), {31'd0, d2f_ready}, 32'd0);
            check($sformatf("bp%0d_pc", i), d2e_pc, 32'h3000);
            check($sformatf("bp%0d_instr", i), d2e_instr, 32'h00100093);
            tick();
        end
        e2d_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, d2f_ready}, 32'd1);
        tick();
        check("bp_next_pc", d2e_pc, 32'h3004);
        f2d_valid = 1'b0;
        tick();

        // CSRRW serializes until START_BRANCH
        f2d_valid = 1'b1;
        f2d_pc = 32'h2000;
        f2d_instr = 32'h30009073;
        e2d_ready = 1'b1;
        tick();
        e2d_ready = 1'b0;
        f2d_pc = 32'h2004;
        f2d_instr = 32'h00000013;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("csr%0d_ready", i), {31'd0, d2f_ready}, 32'd0);
            tick();
        end
        check("csr_held_pc", d2e_pc, 32'h2000);
        e2d_cmd = ARMLEOCPU_D2F_CMD_START_BRANCH;
        e2d_branchtarget = 32'h2004;
        #1;
        check("csr_d2f_cmd", {30'd0, d2f_cmd}, {30'd0, ARMLEOCPU_D2F_CMD_START_BRANCH});
        check("csr_target", d2f_branchtarget, 32'h2004);
        check("csr_kill_ready", {31'd0, d2f_ready}, 32'd1);
        tick();
        e2d_cmd = ARMLEOCPU_D2F_CMD_NONE;
        f2d_valid = 1'b0;
        check("csr_valid_after", {31'd0, d2e_valid}, 32'd0);
        check("csr_busy_after", {31'd0, dbg_pipeline_busy}, 32'd0);

        // Kill drops a valid incoming beat
        f2d_valid = 1'b1;
        f2d_instr = 32'h00000013;
        f2d_pc = 32'h4000;
        e2d_cmd = ARMLEOCPU_D2F_CMD_FLUSH;
        tick();
        e2d_cmd = ARMLEOCPU_D2F_CMD_NONE;
        f2d_valid = 1'b0;
        check("kill_drop_valid", {31'd0, d2e_valid}, 32'd0);

        // Interrupt-pending beat
        f2d_valid = 1'b1;
        f2d_type = F2E_TYPE_INTERRUPT_PENDING;
        f2d_instr = 32'hFFFFFFFF;
        f2d_pc = 32'h5000;
        e2d_ready = 1'b0;
        tick();
        f2d_type = F2E_TYPE_INSTR;
        f2d_instr = 32'h00000013;
        check("irq_type", {30'd0, d2e_type}, {30'd0, F2E_TYPE_INTERRUPT_PENDING});
        check("irq_illegal", {31'd0, d2e_illegal}, 32'd0);
        check("irq_imm", d2e_imm, 32'd0);
        e2d_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("irq%0d_ready", i), {31'd0, d2f_ready}, 32'd0);
            tick();
        end
        e2d_cmd = ARMLEOCPU_D2F_CMD_FLUSH;
        #1;
        check("irq_flush_ready", {31'd0, d2f_ready}, 32'd1);
        tick();
        e2d_cmd = ARMLEOCPU_D2F_CMD_NONE;
        f2d_valid = 1'b0;
        check("irq_cleared", {31'd0, dbg_pipeline_busy}, 32'd0);

        // Reset while serializing
        f2d_valid = 1'b1;
        f2d_instr = 32'h00000073;
        f2d_pc = 32'h6000;
        e2d_ready = 1'b0;
        tick();
        f2d_valid = 1'b0;
        check("rs_busy_before", {31'd0, dbg_pipeline_busy}, 32'd1);
        rst = 1'b1;
        e2d_cmd = ARMLEOCPU_D2F_CMD_FLUSH;
        #1;
        check("rs_ready_in_rst", {31'd0, d2f_ready}, 32'd0);
        check("rs_cmd_in_rst", {30'd0, d2f_cmd}, 32'd0);
        tick();
        rst = 1'b0;
        e2d_cmd = ARMLEOCPU_D2F_CMD_NONE;
        #1;
        check("rs_valid_after", {31'd0, d2e_valid}, 32'd0);
        check("rs_busy_after", {31'd0, dbg_pipeline_busy}, 32'd0);
        check("rs_ready_after", {31'd0, d2f_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
